sr_flag_bank: RTL and testbench

SR_FLAG_BANK -- requirements
Module: sr_flag_bank

---
 rtl/sr_pkg.sv | 30 +++
 rtl/sr_cell.sv | 123 ++++++++++++
 rtl/sr_flag_bank_chk.sv | 20 ++
 rtl/sr_flag_bank.sv | 72 +++++++
 tb/tb_sr_flag_bank.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg -- shared definitions for the SR flag bank.
//   * MODE_* : what a channel does when set and reset are active together.
//   * satInc : saturating increment used by the per-channel event counters.
// -----------------------------------------------------------------------------
package sr_pkg;

  localparam logic [1:0] MODE_RDOM   = 2'd0;  // reset wins -> 0
  localparam logic [1:0] MODE_SDOM   = 2'd1;  // set wins   -> 1
  localparam logic [1:0] MODE_TOGGLE = 2'd2;  // both       -> ~q
  localparam logic [1:0] MODE_HOLD   = 2'd3;  // both       -> q

  // Increment value, stopping at the all-ones value of a counter of 'width'
  // bits. The operand is zero-extended to 32 bits by the caller.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input int unsigned width);
    logic [31:0] maxVal;
    if (width >= 32'd32) begin
      maxVal = 32'hFFFF_FFFF;
    end else begin
      maxVal = (32'd1 << width) - 32'd1;
    end
    if (value >= maxVal) begin
      satInc = maxVal;
    end else begin
      satInc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/sr_cell.sv
// -----------------------------------------------------------------------------
// sr_cell -- one SR flag channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update enable for q (also gates rise and counting)
//   s, r       : set / reset request for this channel
//   cntClr     : synchronous clear of the event counter
//   q          : registered channel state
//   rise       : registered one-cycle pulse when q goes 0->1
//   cnt        : saturating count of q 0->1 transitions
// -----------------------------------------------------------------------------
module sr_cell
  import sr_pkg::*;
#(
  parameter int          MODE  = 0,
  parameter int          EDGE  = 0,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             cntClr,
  output logic             q,
  output logic             rise,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [1:0] MODE_L = 2'(MODE);

  logic             sD_r;
  logic             rD_r;
  logic             q_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  logic             sEff_s;
  logic             rEff_s;
  logic             qNext_s;
  logic             incr_s;
  logic [CNT_W-1:0] cntNext_s;

  // Request history for edge detection; sampled every cycle even with en low,
  // so an edge that happens while disabled is consumed and lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sD_r <= 1'b0;
      rD_r <= 1'b0;
    end else begin
      sD_r <= s;
      rD_r <= r;
    end
  end

  // Effective requests: raw levels, or rising edges only.
  always_comb begin
    sEff_s = s;
    rEff_s = r;
    if (EDGE == 32'sd1) begin
      sEff_s = s & ~sD_r;
      rEff_s = r & ~rD_r;
    end else begin
      sEff_s = s;
      rEff_s = r;
    end
  end

  // Next channel state, with MODE resolving the set+reset collision.
  always_comb begin
    qNext_s = q_r;
    case ({sEff_s, rEff_s})
      2'b10: qNext_s = 1'b1;
      2'b01: qNext_s = 1'b0;
      2'b11: begin
        case (MODE_L)
          MODE_RDOM:   qNext_s = 1'b0;
          MODE_SDOM:   qNext_s = 1'b1;
          MODE_TOGGLE: qNext_s = ~q_r;
          MODE_HOLD:   qNext_s = q_r;
          default:     qNext_s = q_r;
        endcase
      end
      default: qNext_s = q_r;
    endcase
  end

  // A 0->1 transition only happens when the update is enabled; that single
  // condition drives both the rise pulse and the counter.
  always_comb begin
    incr_s    = en & qNext_s & ~q_r;
    cntNext_s = cnt_r;
    if (cntClr) begin
      // Clear wins over the old value but still records a coincident event.
      cntNext_s = incr_s ? CNT_W'(1'b1) : '0;
    end else if (incr_s) begin
      cntNext_s = CNT_W'(satInc(32'(cnt_r), CNT_W));
    end else begin
      cntNext_s = cnt_r;
    end
  end

  // Channel state, rise pulse and event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      if (en) begin
        q_r <= qNext_s;
      end else begin
        q_r <= q_r;
      end
      rise_r <= incr_s;
      cnt_r  <= cntNext_s;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/sr_flag_bank_chk.sv
// -----------------------------------------------------------------------------
// sr_flag_bank_chk -- property checker for sr_flag_bank outputs.
//   clk   : sampling clock (checked on the falling edge, away from updates)
//   q     : channel state
//   q_n   : must always be the complement of q
//   any_q : must always be the OR of q
// -----------------------------------------------------------------------------
module sr_flag_bank_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] q_n,
  input logic             any_q
);

  aQnComplement: assert property (@(negedge clk) q_n == ~q);
  aAnyOr:        assert property (@(negedge clk) any_q == (|q));

endmodule

// File: rtl/sr_flag_bank.sv
// -----------------------------------------------------------------------------
// sr_flag_bank -- bank of WIDTH independent SR flags with event counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update enable for q
//   s, r       : per-channel set / reset requests
//   cnt_clr    : synchronous clear of all event counters
//   sel        : counter read select (values >= WIDTH read as 0)
//   q, q_n     : registered channel state and its complement
//   rise       : registered one-cycle pulse per channel on q 0->1
//   any_q      : OR of all q bits
//   cnt        : event counter of channel sel
// -----------------------------------------------------------------------------
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          MODE  = 0,
  parameter int          EDGE  = 0,
  parameter int unsigned CNT_W = 4,
  parameter int          SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             cnt_clr,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] rise,
  output logic             any_q,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cntArr_s [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : gCell
    sr_cell #(
      .MODE  (MODE),
      .EDGE  (EDGE),
      .CNT_W (CNT_W)
    ) uCell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .s      (s[g]),
      .r      (r[g]),
      .cntClr (cnt_clr),
      .q      (q[g]),
      .rise   (rise[g]),
      .cnt    (cntArr_s[g])
    );
  end

  // q_n is derived from the same register as q, so 1/1 can never appear.
  assign q_n   = ~q;
  assign any_q = |q;

  // Counter read mux; a select beyond the bank falls through to zero.
  always_comb begin
    cnt = '0;
    for (int i = 32'sd0; i < WIDTH; i++) begin
      if (32'(sel) == 32'(i)) begin
        cnt = cntArr_s[i];
      end else begin
        cnt = cnt;
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
module tb_sr_flag_bank;

  localparam int W  = 8;
  localparam int NI = 3;  // 0: MODE0/level, 1: MODE2/level, 2: MODE1/edge

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [7:0] s = 8'h00;
  logic [7:0] r = 8'h00;
  logic [3:0] sel = 4'd0;

  logic [7:0] dq [NI];
  logic [7:0] dqn [NI];
  logic [7:0] drise [NI];
  logic       dany [NI];
  logic [3:0] dcnt [NI];

  int nCheck = 0;
  int nPass  = 0;

  // reference model state: channel value, pulse, event count, previous requests
  bit mq [NI][W];
  bit mr [NI][W];
  bit ps [NI][W];
  bit pr [NI][W];
  int mc [NI][W];

  always #5 clk = ~clk;

  sr_flag_bank #(.WIDTH(8), .MODE(0), .EDGE(0), .CNT_W(4), .SEL_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr), .sel(sel),
    .q(dq[0]), .q_n(dqn[0]), .rise(drise[0]), .any_q(dany[0]), .cnt(dcnt[0]));
  sr_flag_bank #(.WIDTH(8), .MODE(2), .EDGE(0), .CNT_W(4), .SEL_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr), .sel(sel),
    .q(dq[1]), .q_n(dqn[1]), .rise(drise[1]), .any_q(dany[1]), .cnt(dcnt[1]));
  sr_flag_bank #(.WIDTH(8), .MODE(1), .EDGE(1), .CNT_W(4), .SEL_W(4)) dutC (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr), .sel(sel),
    .q(dq[2]), .q_n(dqn[2]), .rise(drise[2]), .any_q(dany[2]), .cnt(dcnt[2]));

  sr_flag_bank_chk #(.WIDTH(8)) chkA (.clk(clk), .q(dq[0]), .q_n(dqn[0]), .any_q(dany[0]));
  sr_flag_bank_chk #(.WIDTH(8)) chkB (.clk(clk), .q(dq[1]), .q_n(dqn[1]), .any_q(dany[1]));
  sr_flag_bank_chk #(.WIDTH(8)) chkC (.clk(clk), .q(dq[2]), .q_n(dqn[2]), .any_q(dany[2]));

  function automatic int modeOf(int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction

  function automatic bit edgeOf(int k);
    return (k == 2);
  endfunction

  function automatic logic [7:0] mQ(int k);
    logic [7:0] v;
    for (int i = 0; i < W; i++) v[i] = mq[k][i];
    return v;
  endfunction

  function automatic logic [7:0] mRise(int k);
    logic [7:0] v;
    for (int i = 0; i < W; i++) v[i] = mr[k][i];
    return v;
  endfunction

  function automatic int mCnt(int k);
    return (sel < 4'd8) ? mc[k][sel] : 0;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < W; i++) begin
        mq[k][i] = 0; mr[k][i] = 0; ps[k][i] = 0; pr[k][i] = 0; mc[k][i] = 0;
      end
  endfunction

  // One clock edge of the behavioural model, using the inputs the DUT samples.
  function automatic void modelUpdate();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < W; i++) begin
        bit sv, rv, se, re, nx, up;
        sv = s[i];
        rv = r[i];
        se = edgeOf(k) ? (sv && !ps[k][i]) : sv;
        re = edgeOf(k) ? (rv && !pr[k][i]) : rv;
        if (se && re) begin
          case (modeOf(k))
            0: nx = 0;
            1: nx = 1;
            2: nx = !mq[k][i];
            default: nx = mq[k][i];
          endcase
        end else if (se) nx = 1;
        else if (re) nx = 0;
        else nx = mq[k][i];
        up = en && nx && !mq[k][i];
        if (en) mq[k][i] = nx;
        if (cnt_clr) mc[k][i] = up ? 1 : 0;
        else if (up && mc[k][i] < 15) mc[k][i] = mc[k][i] + 1;
        mr[k][i] = up;
        ps[k][i] = sv;
        pr[k][i] = rv;
      end
  endfunction

  task automatic step();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic prep();
    en = 1'b1; s = 8'h00; r = 8'h00; cnt_clr = 1'b0; step();
    r = 8'hFF; cnt_clr = 1'b1; step();
    r = 8'h00; cnt_clr = 1'b0; step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s = 8'hFF; en = 1'b1; sel = 4'd0;
    #2;
    for (int k = 0; k < NI; k++) begin
      nCheck++; if (dq[k] !== 8'h00) $display("FAIL reset_q[%0d]: got %h want 00", k, dq[k]); else nPass++;
      nCheck++; if (dqn[k] !== 8'hFF) $display("FAIL reset_qn[%0d]: got %h want ff", k, dqn[k]); else nPass++;
      nCheck++; if (drise[k] !== 8'h00) $display("FAIL reset_rise[%0d]: got %h want 00", k, drise[k]); else nPass++;
      nCheck++; if (dany[k] !== 1'b0) $display("FAIL reset_any[%0d]: got %b want 0", k, dany[k]); else nPass++;
      nCheck++; if (dcnt[k] !== 4'd0) $display("FAIL reset_cnt[%0d]: got %0d want 0", k, dcnt[k]); else nPass++;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      nCheck++; if (dq[k] !== 8'h00) $display("FAIL reset_held_q[%0d]: got %h want 00", k, dq[k]); else nPass++;
    end
    s = 8'h00; r = 8'h00;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_set_basic();
    sel = 4'd0; s = 8'h01; r = 8'h00; step();
    nCheck++; if (dq[0][0] !== 1'b1) $display("FAIL set_q0: got %b want 1", dq[0][0]); else nPass++;
    nCheck++; if (drise[0][0] !== 1'b1) $display("FAIL set_rise0: got %b want 1", drise[0][0]); else nPass++;
    s = 8'h00; step();
    nCheck++; if (drise[0][0] !== 1'b0) $display("FAIL set_rise0_end: got %b want 0", drise[0][0]); else nPass++;
    nCheck++; if (dq[0][0] !== 1'b1) $display("FAIL set_hold_q0: got %b want 1", dq[0][0]); else nPass++;
    nCheck++; if (dcnt[0] !== 4'd1) $display("FAIL set_cnt0: got %0d want 1", dcnt[0]); else nPass++;
    s = 8'h01; r = 8'h01; step();
    nCheck++; if (dq[0][0] !== 1'b0) $display("FAIL rdom_q0: got %b want 0", dq[0][0]); else nPass++;
    s = 8'h00; r = 8'h00;
  endtask

  task automatic test_toggle();
    prep();
    sel = 4'd3; s = 8'h08; r = 8'h08;
    for (int c = 0; c < 4; c++) begin
      step();
      nCheck++; if (dq[1][3] !== ((c % 2) == 0)) $display("FAIL toggle_q3 c%0d: got %b want %b", c, dq[1][3], (c % 2) == 0); else nPass++;
      nCheck++; if (drise[1][3] !== ((c % 2) == 0)) $display("FAIL toggle_rise3 c%0d: got %b want %b", c, drise[1][3], (c % 2) == 0); else nPass++;
    end
    s = 8'h00; r = 8'h00; step();
    nCheck++; if (dcnt[1] !== 4'd2) $display("FAIL toggle_cnt3: got %0d want 2", dcnt[1]); else nPass++;
  endtask

  task automatic test_edge();
    prep();
    sel = 4'd1; s = 8'h02; r = 8'h00;
    for (int c = 0; c < 5; c++) begin
      step();
      nCheck++; if (dq[2][1] !== 1'b1) $display("FAIL edge_q1 c%0d: got %b want 1", c, dq[2][1]); else nPass++;
      nCheck++; if (drise[2][1] !== (c == 0)) $display("FAIL edge_rise1 c%0d: got %b want %b", c, drise[2][1], c == 0); else nPass++;
    end
    nCheck++; if (dcnt[2] !== 4'd1) $display("FAIL edge_cnt1: got %0d want 1", dcnt[2]); else nPass++;
    s = 8'h00; r = 8'h02; step();
    nCheck++; if (dq[2][1] !== 1'b0) $display("FAIL edge_reset_q1: got %b want 0", dq[2][1]); else nPass++;
    r = 8'h00; step();
    en = 1'b0; s = 8'h02; step();
    nCheck++; if (dq[2][1] !== 1'b0) $display("FAIL edge_en0_q1: got %b want 0", dq[2][1]); else nPass++;
    nCheck++; if (drise[2][1] !== 1'b0) $display("FAIL edge_en0_rise1: got %b want 0", drise[2][1]); else nPass++;
    en = 1'b1; step();
    nCheck++; if (dq[2][1] !== 1'b0) $display("FAIL edge_lost_q1: got %b want 0", dq[2][1]); else nPass++;
    s = 8'h00;
  endtask

  task automatic test_saturation();
    prep();
    sel = 4'd2;
    for (int i = 0; i < 20; i++) begin
      s = 8'h04; r = 8'h00; step();
      s = 8'h00; r = 8'h04; step();
      nCheck++; if (dcnt[0] !== 4'((i + 1 > 15) ? 15 : i + 1)) $display("FAIL sat_cnt2 i%0d: got %0d want %0d", i, dcnt[0], (i + 1 > 15) ? 15 : i + 1); else nPass++;
    end
    s = 8'h04; r = 8'h00; cnt_clr = 1'b1; step();
    nCheck++; if (dcnt[0] !== 4'd1) $display("FAIL clr_incr_cnt2: got %0d want 1", dcnt[0]); else nPass++;
    s = 8'h00; step();
    nCheck++; if (dcnt[0] !== 4'd0) $display("FAIL clr_cnt2: got %0d want 0", dcnt[0]); else nPass++;
    cnt_clr = 1'b0;
  endtask

  task automatic test_sel_oob();
    sel = 4'd2; r = 8'h04; step();
    r = 8'h00; s = 8'h04; step();
    s = 8'h00;
    nCheck++; if (dcnt[0] !== 4'd1) $display("FAIL sel2_cnt: got %0d want 1", dcnt[0]); else nPass++;
    sel = 4'd8; #1;
    for (int k = 0; k < NI; k++) begin
      nCheck++; if (dcnt[k] !== 4'd0) $display("FAIL sel8_cnt[%0d]: got %0d want 0", k, dcnt[k]); else nPass++;
    end
    sel = 4'd15; #1;
    nCheck++; if (dcnt[0] !== 4'd0) $display("FAIL sel15_cnt: got %0d want 0", dcnt[0]); else nPass++;
    sel = 4'd0;
  endtask

  task automatic test_async_reset();
    prep();
    sel = 4'd0; s = 8'hA5; r = 8'h5A; step();
    nCheck++; if (dq[0] !== 8'hA5) $display("FAIL pre_rst_q: got %h want a5", dq[0]); else nPass++;
    s = 8'h00; r = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    for (int k = 0; k < NI; k++) begin
      nCheck++; if (dq[k] !== 8'h00) $display("FAIL async_q[%0d]: got %h want 00", k, dq[k]); else nPass++;
      nCheck++; if (dqn[k] !== 8'hFF) $display("FAIL async_qn[%0d]: got %h want ff", k, dqn[k]); else nPass++;
      nCheck++; if (dany[k] !== 1'b0) $display("FAIL async_any[%0d]: got %b want 0", k, dany[k]); else nPass++;
      nCheck++; if (dcnt[k] !== 4'd0) $display("FAIL async_cnt[%0d]: got %0d want 0", k, dcnt[k]); else nPass++;
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < NI; k++) begin
      nCheck++; if (drise[k] !== 8'h00) $display("FAIL release_rise[%0d]: got %h want 00", k, drise[k]); else nPass++;
      nCheck++; if (dq[k] !== 8'h00) $display("FAIL release_q[%0d]: got %h want 00", k, dq[k]); else nPass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s = 8'($urandom) & 8'($urandom);
      r = 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      sel = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < NI; k++) begin
        nCheck++; if (dq[k] !== mQ(k)) $display("FAIL rand_q[%0d] c%0d: got %h want %h", k, c, dq[k], mQ(k)); else nPass++;
        nCheck++; if (dqn[k] !== ~mQ(k)) $display("FAIL rand_qn[%0d] c%0d: got %h want %h", k, c, dqn[k], ~mQ(k)); else nPass++;
        nCheck++; if (drise[k] !== mRise(k)) $display("FAIL rand_rise[%0d] c%0d: got %h want %h", k, c, drise[k], mRise(k)); else nPass++;
        nCheck++; if (dany[k] !== (mQ(k) != 8'h00)) $display("FAIL rand_any[%0d] c%0d: got %b want %b", k, c, dany[k], mQ(k) != 8'h00); else nPass++;
        nCheck++; if (dcnt[k] !== 4'(mCnt(k))) $display("FAIL rand_cnt[%0d] c%0d sel %0d: got %0d want %0d", k, c, sel, dcnt[k], mCnt(k)); else nPass++;
      end
    end
    cnt_clr = 1'b0; en = 1'b1; s = 8'h00; r = 8'h00;
  endtask

  initial begin
    test_reset();
    test_set_basic();
    test_toggle();
    test_edge();
    test_saturation();
    test_sel_oob();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
